// File: rtl/dependent_variable_encoding.sv
// Packs variable-length slice header fields (frame_num length from the SPS) MSB-first into 16-bit words.
// Optional macro DEPENDENT_VARIABLE_STOP_BIT_EN: a flush inserts a single 1 stop bit before zero alignment.
`ifndef FRAME_NUM_S
`define FRAME_NUM_S 4'd2
`endif

module dependent_variable_encoding (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  slice_header_state,
   input  logic [3:0]  log2_max_frame_num_minus4,
   input  logic [3:0]  fixed_len,
   input  logic [9:0]  field_value,
   input  logic        field_valid,
   output logic        field_ready,
   input  logic        flush_req,
   output logic [15:0] word_out,
   output logic        word_valid,
   input  logic        word_ready,
   output logic        flush_done,
   output logic        len_error
);

   localparam logic [2:0] S_RUN        = 3'd0;
   localparam logic [2:0] S_FLUSH_WAIT = 3'd1;
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
   localparam logic [2:0] S_FLUSH_STOP = 3'd2;
`endif
   localparam logic [2:0] S_FLUSH_PAD  = 3'd3;
   localparam logic [2:0] S_DRAIN      = 3'd4;
   localparam logic [2:0] S_DONE       = 3'd5;

   logic [25:0] r_acc;
   logic [4:0]  r_count;
   logic [2:0]  r_state;
   logic        r_len_error;

   logic [4:0]  w_len;
   logic        w_len_legal;
   logic [9:0]  w_mask;
   logic [5:0]  w_app_shift;
   logic [25:0] w_field_bits;
   logic        w_field_fire;
   logic        w_word_fire;

   always_comb begin
      w_len = {1'b0, fixed_len};
      if (slice_header_state == `FRAME_NUM_S)
         w_len = {1'b0, log2_max_frame_num_minus4} + 5'd4;
   end

   assign w_len_legal  = (w_len <= 5'd10);
   assign w_mask       = ~(10'h3FF << w_len);
   // Count is at most 15 on accept and length at most 10, so the shift never underflows for legal fields.
   assign w_app_shift  = 6'd26 - {1'b0, r_count} - {1'b0, w_len};
   assign w_field_bits = {16'd0, field_value & w_mask} << w_app_shift;

   assign field_ready  = !reset && (r_state == S_RUN) && (r_count < 5'd16) && !flush_req;
   assign word_valid   = !reset && ((r_count >= 5'd16) || (r_state == S_DRAIN));
   assign word_out     = r_acc[25:10];
   assign flush_done   = !reset && (r_state == S_DONE);
   assign len_error    = r_len_error;

   assign w_field_fire = field_valid && field_ready;
   assign w_word_fire  = word_valid && word_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_acc       <= 26'd0;
         r_count     <= 5'd0;
         r_state     <= S_RUN;
         r_len_error <= 1'b0;
      end else begin
         if (w_word_fire) begin
            r_acc   <= {r_acc[9:0], 16'd0};
            r_count <= r_count - 5'd16;
         end else if (w_field_fire && w_len_legal) begin
            r_acc   <= r_acc | w_field_bits;
            r_count <= r_count + w_len;
         end
         if (w_field_fire && !w_len_legal)
            r_len_error <= 1'b1;

         case (r_state)
            S_RUN: begin
               if (flush_req)
                  r_state <= S_FLUSH_WAIT;
            end
            S_FLUSH_WAIT: begin
               if (r_count < 5'd16) begin
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
                  r_state <= S_FLUSH_STOP;
`else
                  r_state <= S_FLUSH_PAD;
`endif
               end
            end
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
            S_FLUSH_STOP: begin
               r_acc   <= r_acc | (26'd1 << (6'd25 - {1'b0, r_count}));
               r_count <= r_count + 5'd1;
               r_state <= S_FLUSH_PAD;
            end
`endif
            S_FLUSH_PAD: begin
               // A full word here is handed off by the shared transfer path before padding resumes.
               if (r_count == 5'd0) begin
                  r_state <= S_DONE;
               end else if (r_count != 5'd16) begin
                  r_count <= 5'd16;
                  r_state <= S_DRAIN;
               end
            end
            S_DRAIN: begin
               if (w_word_fire) begin
                  r_acc   <= 26'd0;
                  r_count <= 5'd0;
                  r_state <= S_DONE;
               end
            end
            S_DONE:  r_state <= S_RUN;
            default: r_state <= S_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_dependent_variable_encoding.sv
// Directed bench for dependent_variable_encoding; expectations follow DEPENDENT_VARIABLE_STOP_BIT_EN.
`ifndef FRAME_NUM_S
`define FRAME_NUM_S 4'd2
`endif

module tb_dependent_variable_encoding;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  slice_header_state;
   logic [3:0]  log2_max_frame_num_minus4;
   logic [3:0]  fixed_len;
   logic [9:0]  field_value;
   logic        field_valid;
   logic        field_ready;
   logic        flush_req;
   logic [15:0] word_out;
   logic        word_valid;
   logic        word_ready;
   logic        flush_done;
   logic        len_error;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   dependent_variable_encoding dut (
      .clk                       (clk),
      .reset                     (reset),
      .slice_header_state        (slice_header_state),
      .log2_max_frame_num_minus4 (log2_max_frame_num_minus4),
      .fixed_len                 (fixed_len),
      .field_value               (field_value),
      .field_valid               (field_valid),
      .field_ready               (field_ready),
      .flush_req                 (flush_req),
      .word_out                  (word_out),
      .word_valid                (word_valid),
      .word_ready                (word_ready),
      .flush_done                (flush_done),
      .len_error                 (len_error)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [3:0] st, input logic [3:0] fl, input logic [9:0] v);
      int n = 0;
      slice_header_state = st;
      fixed_len          = fl;
      field_value        = v;
      field_valid        = 1'b1;
      #1;
      while (!field_ready && n < 20) begin
         tick;
         n++;
      end
      chk("send_ready_timeout", 32'(n < 20), 1);
      tick;
      field_valid = 1'b0;
   endtask

   task automatic recv(input string tag, input logic [15:0] exp);
      int n = 0;
      while (!word_valid && n < 20) begin
         tick;
         n++;
      end
      chk({tag, "_vld"}, 32'(word_valid), 1);
      chk(tag, 32'(word_out), 32'(exp));
      word_ready = 1'b1;
      tick;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (!flush_done && n < 10) begin
         tick;
         n++;
      end
      chk(tag, 32'(flush_done), 1);
      tick;
      chk({tag, "_pulse"}, 32'(flush_done), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic seen_vld;
      logic seen_done;

      reset = 1'b1;
      slice_header_state = 4'd0;
      log2_max_frame_num_minus4 = 4'd0;
      fixed_len = 4'd0;
      field_value = 10'd0;
      field_valid = 1'b0;
      flush_req = 1'b0;
      word_ready = 1'b0;
      tick;
      tick;
      chk("rst_field_ready", 32'(field_ready), 0);
      chk("rst_word_valid", 32'(word_valid), 0);
      chk("rst_flush_done", 32'(flush_done), 0);
      chk("rst_len_error", 32'(len_error), 0);
      reset = 1'b0;
      #1;
      chk("run_field_ready", 32'(field_ready), 1);
      chk("run_word_valid", 32'(word_valid), 0);

      // Four 4-bit frame_num fields fill exactly one word; hold it with word_ready low.
      repeat (4) send(`FRAME_NUM_S, 4'd0, 10'h00A);
      chk("t1_latency_vld", 32'(word_valid), 1);
      chk("t1_word", 32'(word_out), 32'h0000AAAA);
      for (int i = 0; i < 20; i++) begin
         chk("t1_stall_word", 32'(word_out), 32'h0000AAAA);
         chk("t1_stall_ready", 32'(field_ready), 0);
         tick;
      end
      word_ready = 1'b1;
      tick;
      chk("t1_single_xfer", 32'(word_valid), 0);
      chk("t1_ready_again", 32'(field_ready), 1);

      // Two 10-bit fields, then flush the 4-bit residue.
      log2_max_frame_num_minus4 = 4'd6;
      send(`FRAME_NUM_S, 4'd0, 10'h3FF);
      send(`FRAME_NUM_S, 4'd0, 10'h001);
      recv("t2_word", 16'hFFC0);
      chk("t2_residual_ready", 32'(field_ready), 1);
      flush_req = 1'b1;
      #1;
      chk("t2_flush_blocks_ready", 32'(field_ready), 0);
      tick;
      flush_req = 1'b0;
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
      recv("t2_flush_word", 16'h1800);
`else
      recv("t2_flush_word", 16'h1000);
`endif
      wait_done("t2_done");

      // Length 11 and 15 are consumed without effect; zero-length adds nothing.
      log2_max_frame_num_minus4 = 4'd7;
      send(`FRAME_NUM_S, 4'd0, 10'h3FF);
      chk("t3_len_error", 32'(len_error), 1);
      chk("t3_no_word", 32'(word_valid), 0);
      send(4'd0, 4'd15, 10'h3FF);
      send(4'd0, 4'd0, 10'h3FF);
      send(4'd0, 4'd8, 10'h0A5);
      chk("t3_count_unchanged", 32'(word_valid), 0);
      send(4'd0, 4'd8, 10'h33C);
      recv("t3_word", 16'hA53C);
      chk("t3_sticky", 32'(len_error), 1);

      // Flush with nothing buffered.
      flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
      recv("t4_stop_word", 16'h8000);
      wait_done("t4_done");
`else
      seen_vld = word_valid;
      n = 0;
      while (!flush_done && n < 3) begin
         tick;
         n++;
         seen_vld = seen_vld | word_valid;
      end
      chk("t4_done_in_3", 32'(flush_done), 1);
      chk("t4_no_word", 32'(seen_vld), 0);
      tick;
      chk("t4_done_pulse", 32'(flush_done), 0);
`endif

      // Reset while a padded word sits in DRAIN.
      word_ready = 1'b0;
      send(4'd0, 4'd4, 10'h005);
      flush_req = 1'b1;
      tick;
      flush_req = 1'b0;
      n = 0;
      while (!word_valid && n < 10) begin
         tick;
         n++;
      end
      chk("t5_drain_vld", 32'(word_valid), 1);
`ifdef DEPENDENT_VARIABLE_STOP_BIT_EN
      chk("t5_drain_word", 32'(word_out), 32'h00005800);
`else
      chk("t5_drain_word", 32'(word_out), 32'h00005000);
`endif
      reset = 1'b1;
      tick;
      chk("t5_rst_vld", 32'(word_valid), 0);
      chk("t5_rst_ready", 32'(field_ready), 0);
      chk("t5_rst_done", 32'(flush_done), 0);
      reset = 1'b0;
      #1;
      chk("t5_run_ready", 32'(field_ready), 1);
      chk("t5_len_error_clr", 32'(len_error), 0);
      word_ready = 1'b1;
      seen_vld  = 1'b0;
      seen_done = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick;
         seen_vld  = seen_vld | word_valid;
         seen_done = seen_done | flush_done;
      end
      chk("t5_no_word", 32'(seen_vld), 0);
      chk("t5_no_done", 32'(seen_done), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
